spi_io_master: RTL
==================

# spi_io_master

Z8S180 I/O-mapped SPI master clocked by `phi`. It replaces the bit-banged GPIO SD-card port with a hardware byte shifter. It provides a programmable SCK divider, all four SPI modes, `NUM_SS` chip selects, and a done/overrun status register. It sits in the top level beside the boot-ROM shadow logic, decodes four I/O ports, and drives the tri-state data bus through `d_out`/`d_oe`.

## Interface
- `BASE_ADDR`, 8'hf0: I/O base address. Must be 4-aligned; decode is `a[7:2]==BASE_ADDR[7:2]`.
- `NUM_SS`, 2: number of slave selects, 1..8.
- `DIV_RESET`, 8'd31: reset value of the DIV register.
- `phi`  in  1  system clock (CPU PHI); the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a`  in  8  CPU address, low byte.
- `d_in`  in  8  CPU data bus, sampled on writes.
- `d_out`  out  8  read data; valid while `d_oe`.
- `d_oe`  out  1  1 = drive the data bus (read decode hit).
- `iorq_n`, `rd_n`, `wr_n`, `m1_n`  in  1 each  CPU bus strobes.
- `sck`  out  1  SPI clock.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in.
- `ss_n`  out  NUM_SS  active-low slave selects.
- `int_n`  out  1  interrupt request; present only with `SPI_IO_MASTER_IRQ_EN`.

## Operation
Register strobes:
- `rd_hit = m1_n & ~iorq_n & ~rd_n & decode`; `wr_hit` is the same with `~wr_n`.
- A write commits on the first `phi` rising edge where `wr_hit` is 1 (the edge-detect register is clear). A read side-effect fires on the first edge of `rd_hit`.
- `d_oe = rd_hit`, combinational. `d_out` is muxed by `a[1:0]`.

Registers, by offset:
- 0 DATA
  - Write while idle: load tx shifter and start a transfer.
  - Write while busy: ignored; set OVR.
  - Read: returns the last received byte and clears DONE.
- 1 CTRL/STATUS
  - Read: `{BUSY, DONE, OVR, IE, 2'b00, CPHA, CPOL}`.
  - Write: bit4 → IE, bit1 → CPHA, bit0 → CPOL. Writing 1 to bit6 clears DONE; writing 1 to bit5 clears OVR.
  - CPOL/CPHA writes are ignored while BUSY.
- 2 DIV: SCK half period is DIV+1 `phi` cycles. Writes ignored while BUSY.
- 3 SSEL: bit i = 1 drives `ss_n[i]` low. Bits at or above NUM_SS read as 0. Writes always take effect immediately.

FSM:
- States: IDLE and SHIFT.
- IDLE → SHIFT on a DATA write: load shifter, `edge_cnt=0`, `div_cnt=DIV`.
- In SHIFT, when `div_cnt==0`: toggle `sck`, increment `edge_cnt`, reload `div_cnt`; otherwise decrement `div_cnt`.
- Odd edges (1, 3, …, 15) are leading edges; even edges are trailing edges.
- CPHA=0: `mosi` = bit7 from start. Sample on leading edges, shift out on trailing edges (the final shift on edge 16 is suppressed).
- CPHA=1: shift out on leading edges (edge 1 presents bit7), sample on trailing edges.
- `miso` is sampled on the same `phi` edge that produces the sampling SCK edge, i.e. the level just before that edge.
- After edge 16, SHIFT → IDLE: rx register updated, BUSY=0, DONE=1.
- Transfers are MSB first, exactly 8 bits. `sck` idles at CPOL; `mosi` idles at 1.

## Timing
- Let T be the `phi` edge that commits a DATA write.
  - BUSY=1 from T.
  - SCK edge n (1..16) occurs at T + n·(DIV+1).
  - rx valid, BUSY=0 and DONE=1 at T + 16·(DIV+1) + 1.
  - With DIV=0, SCK = `phi`/2.
- A DATA write on the completion edge sees the registered BUSY=1: the write is ignored and OVR is set.
- Clearing DONE and completion on the same edge: completion wins, DONE=1.
- Reset values, applied asynchronously, including mid-transfer:
  - `sck`=0, `mosi`=1, `ss_n`=all 1, `int_n`=1.
  - BUSY=DONE=OVR=IE=CPOL=CPHA=0.
  - DIV=DIV_RESET, rx=8'h00, FSM=IDLE.
- `d_out` is combinational with no added wait states.

## Configuration
- `SPI_IO_MASTER_IRQ_EN` defined:
  - `int_n` port exists. It is registered and asserted low while IE & DONE, one `phi` cycle after DONE rises.
  - It deasserts on the cycle after DONE is cleared or IE is written 0.
- Undefined:
  - No `int_n` port.
  - IE bit is not implemented and reads 0.

## Test plan
- Reset, then read offsets 0–3 → 8'h00, 8'h00, 8'd31 (DIV_RESET), 8'h00; `ss_n`=2'b11, `sck`=0, `mosi`=1.
- Mode 0 loopback (`miso`=`mosi`), DIV=1: write SSEL=1, then DATA=8'hA5 → `ss_n[0]`=0; 16 SCK edges at 2-cycle spacing; DONE at T+33; read DATA → 8'hA5 and DONE clears.
- Mode 3 (CPOL=1, CPHA=1), DIV=0, slave model returning 8'h3C → `sck` idles 1; MOSI bit changes on falling edges; rx=8'h3C at T+17.
- Write DATA=8'h55 during a transfer → transmitted byte unchanged; OVR=1; CTRL write of 8'h20 → OVR=0.
- Assert `reset_n` low at SCK edge 7 → all outputs return to reset values immediately; the next transfer after release completes normally.
- With `SPI_IO_MASTER_IRQ_EN`: IE=1, transfer → `int_n`=0 one cycle after DONE; read DATA → `int_n`=1 next cycle.

Source files
------------

// File: rtl/spi_io_master.sv
// spi_io_master: Z8S180 I/O-mapped SPI byte shifter with SCK divider and slave selects.
// Define SPI_IO_MASTER_IRQ_EN to add the IE bit and the int_n output.
module spi_io_master #(
    parameter logic [7:0] BASE_ADDR = 8'hf0,
    parameter int         NUM_SS    = 2,
    parameter logic [7:0] DIV_RESET = 8'd31
) (
    input  logic              phi,
    input  logic              reset_n,
    input  logic [7:0]        a,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_IO_MASTER_IRQ_EN
    output logic              int_n,
`endif
    output logic [NUM_SS-1:0] ss_n
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nx;
    logic              decode, rd_hit, wr_hit, rd_hit_q, wr_hit_q;
    logic              rd_stb, wr_stb, wr_data, wr_ctrl, wr_div, wr_ssel, rd_data;
    logic              busy, start, last, tick, sample, shift_out;
    logic              cpol, cpha, done, ovr, ie, ph, mosi_q;
    logic [4:0]        edge_cnt;
    logic [7:0]        div, div_cnt, tx_sh, rx_sh, rx_data, ssel_rd, status;
    logic [NUM_SS-1:0] ssel;

    assign decode  = (a[7:2] == BASE_ADDR[7:2]);
    assign rd_hit  = m1_n & ~iorq_n & ~rd_n & decode;
    assign wr_hit  = m1_n & ~iorq_n & ~wr_n & decode;
    assign rd_stb  = rd_hit & ~rd_hit_q;
    assign wr_stb  = wr_hit & ~wr_hit_q;
    assign wr_data = wr_stb && (a[1:0] == 2'd0);
    assign wr_ctrl = wr_stb && (a[1:0] == 2'd1);
    assign wr_div  = wr_stb && (a[1:0] == 2'd2);
    assign wr_ssel = wr_stb && (a[1:0] == 2'd3);
    assign rd_data = rd_stb && (a[1:0] == 2'd0);

    assign d_oe = rd_hit;
    assign sck  = cpol ^ ph;
    assign mosi = mosi_q;
    assign ss_n = ~ssel;

    // Bus strobe edge detectors: side effects fire once per access.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            rd_hit_q <= 1'b0;
            wr_hit_q <= 1'b0;
        end else begin
            rd_hit_q <= rd_hit;
            wr_hit_q <= wr_hit;
        end
    end

    // FSM state register.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next state: start on DATA write, leave after the 16th SCK edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (wr_data)              state_nx = SHIFT;
            SHIFT: if (edge_cnt == 5'd16)    state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // FSM outputs: shifter control strobes.
    always_comb begin
        busy      = (state == SHIFT);
        start     = (state == IDLE) && wr_data;
        last      = busy && (edge_cnt == 5'd16);
        tick      = busy && !last && (div_cnt == 8'd0);
        sample    = ~edge_cnt[0] ^ cpha;
        shift_out = (edge_cnt != 5'd15);
    end

    // Divider, SCK phase, tx/rx shifters and MOSI.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            ph       <= 1'b0;
            mosi_q   <= 1'b1;
            edge_cnt <= 5'd0;
            div_cnt  <= 8'd0;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            rx_data  <= 8'h00;
        end else if (start) begin
            ph       <= 1'b0;
            mosi_q   <= cpha ? 1'b1 : d_in[7];
            edge_cnt <= 5'd0;
            div_cnt  <= div;
            tx_sh    <= d_in;
        end else if (last) begin
            rx_data <= rx_sh;
            mosi_q  <= 1'b1;
        end else if (tick) begin
            ph       <= ~ph;
            edge_cnt <= edge_cnt + 5'd1;
            div_cnt  <= div;
            if (sample) begin
                rx_sh <= {rx_sh[6:0], miso};
            end else if (shift_out) begin
                mosi_q <= cpha ? tx_sh[7] : tx_sh[6];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end
        end else if (busy) begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    // Control, divider, select and status registers.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            cpol <= 1'b0;
            cpha <= 1'b0;
            done <= 1'b0;
            ovr  <= 1'b0;
            div  <= DIV_RESET;
            ssel <= '0;
        end else begin
            if (last)                          done <= 1'b1;
            else if (rd_data)                  done <= 1'b0;
            else if (wr_ctrl && d_in[6])       done <= 1'b0;
            if (wr_data && busy)               ovr  <= 1'b1;
            else if (wr_ctrl && d_in[5])       ovr  <= 1'b0;
            if (wr_ctrl && !busy) begin
                cpol <= d_in[0];
                cpha <= d_in[1];
            end
            if (wr_div && !busy)               div  <= d_in;
            if (wr_ssel)                       ssel <= d_in[NUM_SS-1:0];
        end
    end

`ifdef SPI_IO_MASTER_IRQ_EN
    // Interrupt enable and registered, active-low request.
    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            ie    <= 1'b0;
            int_n <= 1'b1;
        end else begin
            if (wr_ctrl) ie <= d_in[4];
            int_n <= ~(ie & done);
        end
    end
`else
    assign ie = 1'b0;
`endif

    // Read data mux.
    always_comb begin
        ssel_rd             = '0;
        ssel_rd[NUM_SS-1:0] = ssel;
        status = {busy, done, ovr, ie, 2'b00, cpha, cpol};
        unique case (a[1:0])
            2'd0:    d_out = rx_data;
            2'd1:    d_out = status;
            2'd2:    d_out = div;
            default: d_out = ssel_rd;
        endcase
    end

endmodule
